sfm_stream_tail_pad: RTL

Load-path stage placed directly downstream of the HCI source streamer and upstream of the softmax datapath. It counts the beats of a vector load. On the final beat of a vector whose byte length is not a multiple of the bus width, it overwrites the invalid tail bytes with a neutral pad pattern, so max/sum reductions are unaffected. This is the load-side counterpart of the store-side strobe generation. It adds one elastic register stage.

---
 rtl/sfm_pkg.sv | 36 +++
 rtl/sfm_stream_elastic_reg.sv | 52 +++++
 rtl/sfm_stream_tail_pad.sv | 103 ++++++++++
 3 files changed

// File: rtl/sfm_pkg.sv
// Shared types and constants for the softmax load/store stream stages.
// Optional feature macro used by the tail pad stage: SFM_TAIL_PAD_STRB_EN.
package sfm_pkg;

    localparam logic [15:0] SFM_BF16_NEG_INF = 16'hFF80;
    localparam logic [15:0] SFM_BF16_ZERO    = 16'h0000;

    // Widest bus the pad-mask helper supports (512-bit stream).
    localparam int unsigned SFM_MAX_BYTES = 64;

    typedef struct packed {
        logic [31:0] tot_len;
        logic [31:0] d0_len;
    } hci_streamer_addressgen_ctrl_t;

    typedef struct packed {
        hci_streamer_addressgen_ctrl_t addressgen_ctrl;
    } hci_streamer_ctrl_t;

    typedef enum logic {
        SFM_EMPTY = 1'b0,
        SFM_FULL  = 1'b1
    } sfm_elastic_state_e;

    // Bit i set when byte i lies at or beyond the valid tail of the vector.
    function automatic logic [SFM_MAX_BYTES-1:0] sfm_pad_mask(input int unsigned lftovr,
                                                              input int unsigned bytes);
        logic [SFM_MAX_BYTES-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < SFM_MAX_BYTES; i++) begin
            m[i] = (i >= lftovr) && (i < bytes);
        end
        return m;
    endfunction

endpackage

// File: rtl/sfm_stream_elastic_reg.sv
// One-entry valid/ready register with a parametric payload; shared by load and store paths.
// Handshake: a beat transfers on a side when valid and ready are both high at the clock edge.
module sfm_stream_elastic_reg
    import sfm_pkg::*;
#(
    parameter int unsigned    W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       out_data,
    output sfm_elastic_state_e state_o
);

    sfm_elastic_state_e state_q, state_d;
    logic [W-1:0]       payload_q;
    logic               load;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= SFM_EMPTY;
            payload_q <= RST_VAL;
        end else begin
            state_q <= state_d;
            if (load) begin
                payload_q <= in_data;
            end
        end
    end

    // Ready looks through to the consumer so a streaming source sees no bubbles.
    always_comb begin
        state_d  = state_q;
        in_ready = (state_q == SFM_EMPTY) | out_ready;
        load     = in_valid & in_ready;
        case (state_q)
            SFM_EMPTY: if (in_valid) state_d = SFM_FULL;
            SFM_FULL:  if (out_ready && !in_valid) state_d = SFM_EMPTY;
            default:   state_d = SFM_EMPTY;
        endcase
    end

    assign out_valid = (state_q == SFM_FULL);
    assign out_data  = payload_q;
    assign state_o   = state_q;

endmodule

// File: rtl/sfm_stream_tail_pad.sv
// Load-path stage: counts vector beats and overwrites the invalid tail bytes of the final beat.
// Define SFM_TAIL_PAD_STRB_EN to also clear the output strobes of padded bytes.
module sfm_stream_tail_pad
    import sfm_pkg::*;
#(
    parameter int unsigned DW       = 128,
    parameter logic [15:0] PAD_ELEM = SFM_BF16_NEG_INF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    input  hci_streamer_ctrl_t stream_ctrl_i,
    input  logic               stream_i_valid,
    output logic               stream_i_ready,
    input  logic [DW-1:0]      stream_i_data,
    input  logic [DW/8-1:0]    stream_i_strb,
    output logic               stream_o_valid,
    input  logic               stream_o_ready,
    output logic [DW-1:0]      stream_o_data,
    output logic [DW/8-1:0]    stream_o_strb,
    output logic               done_o,
    output sfm_elastic_state_e state_o
);

    localparam int unsigned BYTES = DW / 8;
    localparam int unsigned LW    = $clog2(BYTES);
    localparam int unsigned PW    = DW + BYTES + 1;
    localparam logic [PW-1:0] PAYLOAD_RST = {{DW{1'b0}}, {BYTES{1'b1}}, 1'b0};

    logic                     clr;
    logic [31:0]              tot_len;
    logic [31:0]              d0_len;
    logic [LW-1:0]            lftovr;
    logic                     is_lftovr;
    logic                     degenerate;
    logic                     is_last;
    logic                     in_hs;
    logic                     pad_en;
    logic [SFM_MAX_BYTES-1:0] full_mask;
    logic [BYTES-1:0]         pad_mask;
    logic [DW-1:0]            pad_data;
    logic [BYTES-1:0]         pad_strb;
    logic [31:0]              beat_cnt_q;
    logic [DW-1:0]            data_q;
    logic [BYTES-1:0]         strb_q;
    logic                     last_q;
    logic                     unused_bits;

    assign clr        = rst_i | clear_i;
    assign tot_len    = stream_ctrl_i.addressgen_ctrl.tot_len;
    assign d0_len     = stream_ctrl_i.addressgen_ctrl.d0_len;
    assign lftovr     = d0_len[LW-1:0];
    assign is_lftovr  = |lftovr;
    assign degenerate = (tot_len == 32'd0);
    assign is_last    = ~degenerate & (beat_cnt_q == tot_len - 32'd1);
    assign in_hs      = stream_i_valid & stream_i_ready;
    assign pad_en     = is_last & is_lftovr;
    assign full_mask  = sfm_pad_mask({{(32-LW){1'b0}}, lftovr}, BYTES);
    assign pad_mask   = pad_en ? full_mask[BYTES-1:0] : '0;

    // Input strobes carry no information here; the bus is always fully populated on load.
    assign unused_bits = ^{stream_i_strb, d0_len, full_mask};

    always_ff @(posedge clk_i) begin
        if (clr || degenerate) begin
            beat_cnt_q <= 32'd0;
        end else if (in_hs) begin
            beat_cnt_q <= is_last ? 32'd0 : beat_cnt_q + 32'd1;
        end
    end

    // Even bytes take the low pad byte, odd bytes the high one, keeping 16-bit elements intact.
    for (genvar i = 0; i < BYTES; i++) begin : g_pad
        assign pad_data[8*i +: 8] = pad_mask[i] ? PAD_ELEM[8*(i%2) +: 8]
                                                : stream_i_data[8*i +: 8];
    end

`ifdef SFM_TAIL_PAD_STRB_EN
    assign pad_strb = ~pad_mask;
`else
    assign pad_strb = '1;
`endif

    sfm_stream_elastic_reg #(
        .W       (PW),
        .RST_VAL (PAYLOAD_RST)
    ) i_out_reg (
        .clk_i     (clk_i),
        .rst_i     (clr),
        .in_valid  (stream_i_valid),
        .in_ready  (stream_i_ready),
        .in_data   ({pad_data, pad_strb, is_last}),
        .out_valid (stream_o_valid),
        .out_ready (stream_o_ready),
        .out_data  ({data_q, strb_q, last_q}),
        .state_o   (state_o)
    );

    assign stream_o_data = data_q;
    assign stream_o_strb = strb_q;
    assign done_o        = stream_o_valid & stream_o_ready & last_q;

endmodule
